// File: rtl/lcd_pkg.sv
// Shared types, default timing and init command table for the LCD bus scheduler.
// Timing values are in iCLK_50MHZ cycles.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRON,
      ST_INIT_LOAD,
      ST_IDLE,
      ST_SETUP,
      ST_E_HIGH,
      ST_HOLD,
      ST_WAIT
   } lcd_state_t;

   localparam int CNT_W         = 20;
   localparam int T_PWRON_DEF   = 750000;
   localparam int T_SETUP_DEF   = 4;
   localparam int T_EH_DEF      = 16;
   localparam int T_HOLD_DEF    = 4;
   localparam int T_SHORT_DEF   = 2000;
   localparam int T_LONG_DEF    = 82000;
   localparam int INIT_CMD_N    = 4;

   // Function set 8-bit/2-line, display on, clear, entry mode increment.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = 8'h38;
         2'd1:    cmd = 8'h0C;
         2'd2:    cmd = 8'h01;
         default: cmd = 8'h06;
      endcase
      return cmd;
   endfunction

   // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
      return !rs && (dat[7:2] == 6'd0) && (dat[1:0] != 2'd0);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// 20-bit down-counter: start loads N-1, done is high while the count is zero.
// A state timed with load N-1 therefore lasts exactly N cycles; the count never wraps.
module lcd_delay_timer
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] load,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = load;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Two-requester round-robin scheduler driving an HD44780-style LCD bus, with power-on init.
// Accept-to-E-rise is 1+T_SETUP cycles; requesters wait (ready low) until IDLE after init.
module lcd_bus_scheduler
   import lcd_pkg::*;
#(
   parameter int T_PWRON = T_PWRON_DEF,
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_EH    = T_EH_DEF,
   parameter int T_HOLD  = T_HOLD_DEF,
   parameter int T_SHORT = T_SHORT_DEF,
   parameter int T_LONG  = T_LONG_DEF
)
(
   input  logic       iCLK_50MHZ,
   input  logic       iRST_N,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       init_done,
   output logic       busy,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic [7:0] DATA_BUS
);

   localparam logic [CNT_W-1:0] LD_PWRON = CNT_W'(T_PWRON - 1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EH    = CNT_W'(T_EH - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_SHORT - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

   lcd_state_t       state_q, state_d;
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             init_done_q, init_done_d;
   logic [1:0]       init_idx_q, init_idx_d;
   logic             last_q, last_d;
   logic             pwr_armed_q, pwr_armed_d;

   logic             tmr_start;
   logic [CNT_W-1:0] tmr_load;
   logic             tmr_done;
   logic             grant0, grant1;
   logic             idle_open;

   lcd_delay_timer u_timer (
      .clk   (iCLK_50MHZ),
      .rst_n (iRST_N),
      .start (tmr_start),
      .load  (tmr_load),
      .done  (tmr_done)
   );

   // last_q names the requester granted most recently; the other one wins a tie.
   assign idle_open = (state_q == ST_IDLE) && init_done_q;
   assign grant0    = idle_open && req0_valid && (!req1_valid || last_q);
   assign grant1    = idle_open && req1_valid && !grant0;

   always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= ST_PWRON;
         e_q         <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         init_done_q <= 1'b0;
         init_idx_q  <= 2'd0;
         last_q      <= 1'b1;
         pwr_armed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         e_q         <= e_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
         init_idx_q  <= init_idx_d;
         last_q      <= last_d;
         pwr_armed_q <= pwr_armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PWRON:     if (pwr_armed_q && tmr_done) state_d = ST_INIT_LOAD;
         ST_INIT_LOAD: state_d = ST_SETUP;
         ST_IDLE:      if (grant0 || grant1) state_d = ST_SETUP;
         ST_SETUP:     if (tmr_done) state_d = ST_E_HIGH;
         ST_E_HIGH:    if (tmr_done) state_d = ST_HOLD;
         ST_HOLD:      if (tmr_done) state_d = ST_WAIT;
         ST_WAIT: begin
            if (tmr_done) begin
               if (!init_done_q && (init_idx_q != 2'(INIT_CMD_N - 1)))
                  state_d = ST_INIT_LOAD;
               else
                  state_d = ST_IDLE;
            end
         end
         default:      state_d = ST_PWRON;
      endcase
   end

   always_comb begin
      tmr_start   = 1'b0;
      tmr_load    = '0;
      e_d         = (state_d == ST_E_HIGH);
      rs_d        = rs_q;
      data_d      = data_q;
      init_done_d = init_done_q;
      init_idx_d  = init_idx_q;
      last_d      = last_q;
      pwr_armed_d = pwr_armed_q;

      // The power-on wait is armed on its first cycle since reset leaves the counter at zero.
      if (state_q == ST_PWRON && !pwr_armed_q) begin
         tmr_start   = 1'b1;
         tmr_load    = LD_PWRON;
         pwr_armed_d = 1'b1;
      end else if (state_d != state_q) begin
         case (state_d)
            ST_SETUP:  begin tmr_start = 1'b1; tmr_load = LD_SETUP; end
            ST_E_HIGH: begin tmr_start = 1'b1; tmr_load = LD_EH;    end
            ST_HOLD:   begin tmr_start = 1'b1; tmr_load = LD_HOLD;  end
            ST_WAIT: begin
               tmr_start = 1'b1;
               tmr_load  = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_SHORT;
            end
            default: ;
         endcase
      end

      if (state_q == ST_INIT_LOAD) begin
         rs_d   = 1'b0;
         data_d = init_cmd(init_idx_q);
      end

      if (grant0) begin
         rs_d   = req0_rs;
         data_d = req0_data;
         last_d = 1'b0;
      end else if (grant1) begin
         rs_d   = req1_rs;
         data_d = req1_data;
         last_d = 1'b1;
      end

      if (state_q == ST_WAIT && tmr_done && !init_done_q) begin
         if (init_idx_q == 2'(INIT_CMD_N - 1))
            init_done_d = 1'b1;
         else
            init_idx_d = init_idx_q + 2'd1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign init_done  = init_done_q;
   assign busy       = (state_q != ST_IDLE);
   assign LCD_RW     = 1'b0;
   assign LCD_E      = e_q;
   assign LCD_RS     = rs_q;
   assign DATA_BUS   = data_q;

endmodule

// File: doc/lcd_bus_scheduler.md
LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

Interface
REQ-001 Parameters: T_PWRON default 750000 (15 ms power-on wait); T_SETUP default 4 (RS/DATA to E-rise); T_EH default 16 (E high width); T_HOLD default 4 (E-fall to next change); T_SHORT default 2000 (40 us post-write wait); T_LONG default 82000 (1.64 ms clear/home wait).
REQ-002 Ports: iCLK_50MHZ in 1 system clock; iRST_N in 1 reset; single clock, reset asynchronous, active-low.
REQ-003 req0_valid in 1, req0_rs in 1, req0_data in 8: requester 0 write (rs=0 command, 1 character).
REQ-004 req0_ready out 1: one-cycle accept strobe for requester 0.
REQ-005 req1_valid, req1_rs, req1_data, req1_ready: identical set for requester 1.
REQ-006 init_done out 1 high after init sequence completes; busy out 1 high whenever not IDLE.
REQ-007 LCD_RW out 1 (constant 0), LCD_E out 1, LCD_RS out 1, DATA_BUS out 8 (top level drives inout pad).

Function
REQ-008 FSM states: PWRON, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, WAIT.
REQ-009 PWRON: count T_PWRON cycles, then INIT_LOAD.
REQ-010 Init sequence: commands 0x38, 0x0C, 0x01, 0x06 (rs=0), each through SETUP/E_HIGH/HOLD/WAIT; after the 4th WAIT, init_done=1, go IDLE.
REQ-011 reqN_ready asserted only in IDLE with init_done=1 and reqN_valid=1; transfer occurs on that cycle; FSM enters SETUP next cycle.
REQ-012 Both valid in IDLE: grant the requester not granted last (round-robin); single valid: grant it regardless of history.
REQ-013 Requester holds valid/rs/data stable until ready; valid deasserted before ready = no transfer, no error.
REQ-014 On transfer, latch rs/data into LCD_RS/DATA_BUS the next cycle; hold them stable through SETUP, E_HIGH, HOLD.
REQ-015 SETUP lasts T_SETUP cycles (LCD_E=0); E_HIGH lasts T_EH cycles (LCD_E=1); HOLD lasts T_HOLD cycles (LCD_E=0).
REQ-016 WAIT lasts T_LONG when rs=0 and data[7:2]=0 and data[1:0]!=0 (clear/home), else T_SHORT; then IDLE (or next init command).
REQ-017 Accept-to-E-rise latency exactly 1+T_SETUP cycles; earliest next ready is the cycle after WAIT ends.
REQ-018 Delay counter 20 bits, loads N-1 on state entry, counts down, state exits when counter=0; no wrap.
REQ-019 LCD_E glitch-free: registered output, toggles only on SETUP->E_HIGH and E_HIGH->HOLD.
REQ-020 busy=0 only in IDLE; busy=1 in PWRON and throughout init.

Reset
REQ-021 iRST_N low: state PWRON, counter 0, LCD_E=0, LCD_RS=0, DATA_BUS=0x00, LCD_RW=0, both ready=0, init_done=0, busy=1, last-grant=1 (requester 0 wins first tie).
REQ-022 Reset mid-transfer: LCD_E drops immediately (async), in-flight write discarded, full power-on/init sequence reruns after release.

Structure
REQ-023 Package lcd_pkg holds: state enum, default timing constants, 4-entry init command table, long-wait command predicate.
REQ-024 One sub-module lcd_delay_timer (load value, start, done) implements the 20-bit down-counter.

Verification
REQ-025 Bench parameters reduced (T_PWRON=50, T_SHORT=20, T_LONG=80) to keep runs short.
REQ-026 Release reset -> LCD_E pulses exactly 4 times with DATA_BUS 0x38, 0x0C, 0x01, 0x06, RS=0; gap after 0x01 is T_LONG; init_done rises after 4th WAIT.
REQ-027 After init, req0 writes rs=1 data 0x41 -> req0_ready 1 cycle; E rises 1+T_SETUP cycles later, high 16 cycles, RS=1, DATA_BUS=0x41; busy for the whole transfer.
REQ-028 req0 and req1 held valid continuously (0x30 / 0x31) -> grants alternate 0,1,0,1; never two ready in the same cycle.
REQ-029 req1 sends rs=0 0x02 -> WAIT lasts T_LONG; rs=0 0x80 -> WAIT lasts T_SHORT.
REQ-030 Assert iRST_N low during E_HIGH -> LCD_E=0 same cycle, init_done=0; after release, full init sequence repeats, no partial write replays.
